mem_stage_wb: RTL and testbench

- MEM-stage load/store unit fused with the MEM/WB pipeline register; it sits directly downstream of the EXE/MEM register.
- Consumes the EXE/MEM outputs: D_address, store data, funct3, Dcache enable/write, WB control.
- Runs the D-cache request/response handshake, generates Dstall back to the pipeline, aligns and sign-extends load data, and registers the write-back bundle.

---
 rtl/mem_pkg.sv | 39 +++
 rtl/mem_align.sv | 64 ++++++
 rtl/mem_stage_wb.sv | 244 ++++++++++++++++++++++++
 tb/tb_mem_stage_wb.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg
// Shared definitions for the MEM stage / MEM-WB register slice:
//   - mem_state_e   : D-cache handshake FSM states (IDLE, WAIT, HOLD)
//   - F3_*          : funct3 encodings for load/store size and sign
//   - WB_*          : bit positions inside the WB control bundle
//   - is_misaligned : alignment test used by the optional check
//                     (MEM_MISALIGN_CHECK_EN)
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } mem_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int WB_REG_WRITE  = 0;
  localparam int WB_MEM_TO_REG = 1;
  localparam int WB_PC_TO_REG  = 2;

  // Halfwords need an even offset, words need offset zero.
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (funct3)
      F3_H, F3_HU: bad = off[0];
      F3_W:        bad = (off != 2'b00);
      default:     bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_align.sv
// mem_align
// Purely combinational byte-lane logic for the MEM stage.
// Store side: builds byte strobes and replicates store data onto every
// lane so the cache only needs the strobes to pick the right bytes.
// Load side: extracts a byte/half/word from the returned cache word and
// sign- or zero-extends it.
// Ports:
//   st_funct3, st_off, st_data -> st_wstrb, st_wdata
//   ld_funct3, ld_off, ld_rdata -> ld_data
module mem_align
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic [2:0]        st_funct3,
  input  logic [1:0]        st_off,
  input  logic [DATA_W-1:0] st_data,
  output logic [STRB_W-1:0] st_wstrb,
  output logic [DATA_W-1:0] st_wdata,
  input  logic [2:0]        ld_funct3,
  input  logic [1:0]        ld_off,
  input  logic [DATA_W-1:0] ld_rdata,
  output logic [DATA_W-1:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store strobes/data. Halfword ignores off[0], word ignores off.
  always_comb begin
    st_wstrb = '1;
    st_wdata = st_data;
    case (st_funct3)
      F3_B: begin
        st_wstrb = STRB_W'(1) << st_off;
        st_wdata = {STRB_W{st_data[7:0]}};
      end
      F3_H: begin
        st_wstrb = st_off[1] ? STRB_W'(4'b1100) : STRB_W'(4'b0011);
        st_wdata = {(STRB_W/2){st_data[15:0]}};
      end
      default: begin
        st_wstrb = '1;
        st_wdata = st_data;
      end
    endcase
  end

  // Load lane selection and extension.
  always_comb begin
    ld_byte = ld_rdata[{ld_off, 3'b000} +: 8];
    ld_half = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    ld_data = ld_rdata;
    case (ld_funct3)
      F3_B:    ld_data = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data = {{(DATA_W-8){1'b0}}, ld_byte};
      F3_H:    ld_data = {{(DATA_W-16){ld_half[15]}}, ld_half};
      F3_HU:   ld_data = {{(DATA_W-16){1'b0}}, ld_half};
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_wb.sv
// mem_stage_wb
// MEM-stage load/store unit fused with the MEM/WB pipeline register.
// Runs the D-cache request/response handshake, raises Dstall while a
// memory op is outstanding, aligns/extends load data and registers the
// write-back bundle.
// Ports:
//   clk, rst (async, active-low)
//   EXE/MEM inputs : PC_added_MEM, write_addr_MEM, alu_result_MEM,
//                    D_address, Read_data_2_MEM, funct3_MEM, Dcache_en,
//                    Dcache_write, WB_ctr_EXE_MEM
//   global holds   : Istall, wfi_stall
//   D-cache        : Dcache_rdata, Dcache_valid in; Dcache_req, Dcache_we,
//                    Dcache_addr, Dcache_wdata, Dcache_wstrb out
//   pipeline       : Dstall (combinational)
//   MEM/WB         : WB_data, write_addr_WB, reg_write_WB
// Optional: define MEM_MISALIGN_CHECK_EN to add misalign_err and suppress
// misaligned accesses instead of silently aligning them.
module mem_stage_wb
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] PC_added_MEM,
  input  logic [4:0]        write_addr_MEM,
  input  logic [DATA_W-1:0] alu_result_MEM,
  input  logic [DATA_W-1:0] D_address,
  input  logic [DATA_W-1:0] Read_data_2_MEM,
  input  logic [2:0]        funct3_MEM,
  input  logic              Dcache_en,
  input  logic              Dcache_write,
  input  logic [2:0]        WB_ctr_EXE_MEM,
  input  logic              Istall,
  input  logic              wfi_stall,
  input  logic [DATA_W-1:0] Dcache_rdata,
  input  logic              Dcache_valid,
  output logic              Dcache_req,
  output logic              Dcache_we,
  output logic [DATA_W-1:0] Dcache_addr,
  output logic [DATA_W-1:0] Dcache_wdata,
  output logic [STRB_W-1:0] Dcache_wstrb,
  output logic              Dstall,
  output logic [DATA_W-1:0] WB_data,
  output logic [4:0]        write_addr_WB,
`ifdef MEM_MISALIGN_CHECK_EN
  output logic              misalign_err,
`endif
  output logic              reg_write_WB
);

  mem_state_e state_q, state_d;

  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        off_q, off_d;
  logic              req_q, req_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [4:0]        wb_addr_q, wb_addr_d;
  logic              wb_we_q, wb_we_d;

  logic              hold_global;
  logic              misaligned;
  logic              access_start;
  logic              wb_update;
  logic [STRB_W-1:0] st_wstrb;
  logic [DATA_W-1:0] st_wdata;
  logic [DATA_W-1:0] ld_ext;
  logic [DATA_W-1:0] load_data;

  assign hold_global = Istall | wfi_stall;

`ifdef MEM_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;
  assign misaligned = Dcache_en & is_misaligned(funct3_MEM, D_address[1:0]);
  assign misalign_err = misalign_q;
`else
  assign misaligned = 1'b0;
`endif

  // A memory op only enters the handshake when it is not being suppressed.
  assign access_start = Dcache_en & ~misaligned;

  // Store side aligns the live EXE/MEM op; load side uses the latched
  // size/offset because the response arrives cycles later.
  mem_align #(
    .DATA_W(DATA_W),
    .STRB_W(STRB_W)
  ) u_align (
    .st_funct3 (funct3_MEM),
    .st_off    (D_address[1:0]),
    .st_data   (Read_data_2_MEM),
    .st_wstrb  (st_wstrb),
    .st_wdata  (st_wdata),
    .ld_funct3 (funct3_q),
    .ld_off    (off_q),
    .ld_rdata  (Dcache_rdata),
    .ld_data   (ld_ext)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and request-latch logic. The request pulses for exactly
  // one cycle: req_d only rises on the IDLE->WAIT transition.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    off_d    = off_q;
    rdata_d  = rdata_q;
    req_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (access_start) begin
          addr_d   = {D_address[DATA_W-1:2], 2'b00};
          wdata_d  = st_wdata;
          wstrb_d  = st_wstrb;
          we_d     = Dcache_write;
          funct3_d = funct3_MEM;
          off_d    = D_address[1:0];
          req_d    = 1'b1;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (Dcache_valid) begin
          if (hold_global) begin
            rdata_d = ld_ext;
            state_d = HOLD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      HOLD: begin
        if (!hold_global) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: stall generation and MEM/WB next values.
  always_comb begin
    Dstall = 1'b0;
    unique case (state_q)
      IDLE:    Dstall = access_start;
      WAIT:    Dstall = ~Dcache_valid;
      HOLD:    Dstall = 1'b0;
      default: Dstall = 1'b0;
    endcase

    load_data = (state_q == HOLD) ? rdata_q : ld_ext;
    wb_update = ~(hold_global | Dstall);

    wb_data_d = wb_data_q;
    wb_addr_d = wb_addr_q;
    wb_we_d   = wb_we_q;
    if (wb_update) begin
      if (WB_ctr_EXE_MEM[WB_PC_TO_REG]) begin
        wb_data_d = PC_added_MEM;
      end else if (WB_ctr_EXE_MEM[WB_MEM_TO_REG]) begin
        wb_data_d = load_data;
      end else begin
        wb_data_d = alu_result_MEM;
      end
      wb_addr_d = write_addr_MEM;
      wb_we_d   = WB_ctr_EXE_MEM[WB_REG_WRITE] & ~misaligned;
    end
  end

`ifdef MEM_MISALIGN_CHECK_EN
  // Error flag travels with the rest of the MEM/WB bundle.
  always_comb begin
    misalign_d = misalign_q;
    if (wb_update) begin
      misalign_d = misaligned;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end
`endif

  // Datapath registers: request latch, held load data and MEM/WB bundle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      we_q      <= 1'b0;
      funct3_q  <= 3'b000;
      off_q     <= 2'b00;
      req_q     <= 1'b0;
      rdata_q   <= '0;
      wb_data_q <= '0;
      wb_addr_q <= '0;
      wb_we_q   <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      we_q      <= we_d;
      funct3_q  <= funct3_d;
      off_q     <= off_d;
      req_q     <= req_d;
      rdata_q   <= rdata_d;
      wb_data_q <= wb_data_d;
      wb_addr_q <= wb_addr_d;
      wb_we_q   <= wb_we_d;
    end
  end

  assign Dcache_req    = req_q;
  assign Dcache_we     = we_q;
  assign Dcache_addr   = addr_q;
  assign Dcache_wdata  = wdata_q;
  assign Dcache_wstrb  = wstrb_q;
  assign WB_data       = wb_data_q;
  assign write_addr_WB = wb_addr_q;
  assign reg_write_WB  = wb_we_q;

endmodule

// File: tb/tb_mem_stage_wb.sv
// tb_mem_stage_wb
// Directed bench for mem_stage_wb: reset values, ALU pass-through, loads
// of every size with hand-computed results, store strobes/data, the HOLD
// path under Istall, reset during WAIT and a stray Dcache_valid in IDLE.
module tb_mem_stage_wb;

  logic        clk;
  logic        rst;
  logic [31:0] PC_added_MEM;
  logic [4:0]  write_addr_MEM;
  logic [31:0] alu_result_MEM;
  logic [31:0] D_address;
  logic [31:0] Read_data_2_MEM;
  logic [2:0]  funct3_MEM;
  logic        Dcache_en;
  logic        Dcache_write;
  logic [2:0]  WB_ctr_EXE_MEM;
  logic        Istall;
  logic        wfi_stall;
  logic [31:0] Dcache_rdata;
  logic        Dcache_valid;
  logic        Dcache_req;
  logic        Dcache_we;
  logic [31:0] Dcache_addr;
  logic [31:0] Dcache_wdata;
  logic [3:0]  Dcache_wstrb;
  logic        Dstall;
  logic [31:0] WB_data;
  logic [4:0]  write_addr_WB;
  logic        reg_write_WB;
`ifdef MEM_MISALIGN_CHECK_EN
  logic        misalign_err;
`endif

  int errors = 0;
  int checks = 0;

  mem_stage_wb dut (
    .clk             (clk),
    .rst             (rst),
    .PC_added_MEM    (PC_added_MEM),
    .write_addr_MEM  (write_addr_MEM),
    .alu_result_MEM  (alu_result_MEM),
    .D_address       (D_address),
    .Read_data_2_MEM (Read_data_2_MEM),
    .funct3_MEM      (funct3_MEM),
    .Dcache_en       (Dcache_en),
    .Dcache_write    (Dcache_write),
    .WB_ctr_EXE_MEM  (WB_ctr_EXE_MEM),
    .Istall          (Istall),
    .wfi_stall       (wfi_stall),
    .Dcache_rdata    (Dcache_rdata),
    .Dcache_valid    (Dcache_valid),
    .Dcache_req      (Dcache_req),
    .Dcache_we       (Dcache_we),
    .Dcache_addr     (Dcache_addr),
    .Dcache_wdata    (Dcache_wdata),
    .Dcache_wstrb    (Dcache_wstrb),
    .Dstall          (Dstall),
    .WB_data         (WB_data),
    .write_addr_WB   (write_addr_WB),
`ifdef MEM_MISALIGN_CHECK_EN
    .misalign_err    (misalign_err),
`endif
    .reg_write_WB    (reg_write_WB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts one comparison and reports it if it does not match.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drives the EXE/MEM side of the stage.
  task automatic applyStimulus(input logic en, input logic we,
                               input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] sdata, input logic [2:0] wbctr,
                               input logic [31:0] alu, input logic [4:0] waddr);
    Dcache_en       = en;
    Dcache_write    = we;
    funct3_MEM      = f3;
    D_address       = addr;
    Read_data_2_MEM = sdata;
    WB_ctr_EXE_MEM  = wbctr;
    alu_result_MEM  = alu;
    write_addr_MEM  = waddr;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic midCycle();
    @(negedge clk);
  endtask

  // One complete memory op; valid arrives lat cycles after the request.
  // Called at posedge+1 with the FSM in IDLE, returns at posedge+1 after
  // the MEM/WB capture with the EXE/MEM side idle.
  task automatic runAccess(input string tag, input logic we,
                           input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] sdata, input logic [2:0] wbctr,
                           input logic [31:0] alu, input logic [31:0] rdata,
                           input int lat, input logic [3:0] exp_strb,
                           input logic [31:0] exp_wdata,
                           input logic [31:0] exp_wb, input logic exp_rw);
    int stall_cnt;
    stall_cnt = 0;
    applyStimulus(1'b1, we, f3, addr, sdata, wbctr, alu, 5'd9);
    midCycle();
    if (Dstall) stall_cnt++;
    nextCycle();
    midCycle();
    if (Dstall) stall_cnt++;
    checkOutput({tag, "_req"}, 32'(Dcache_req), 32'd1);
    checkOutput({tag, "_addr"}, Dcache_addr, addr & 32'hFFFF_FFFC);
    checkOutput({tag, "_we"}, 32'(Dcache_we), 32'(we));
    if (we) begin
      checkOutput({tag, "_wstrb"}, 32'(Dcache_wstrb), 32'(exp_strb));
      checkOutput({tag, "_wdata"}, Dcache_wdata, exp_wdata);
    end
    for (int i = 1; i < lat; i++) begin
      nextCycle();
      if (i == 1) checkOutput({tag, "_req_pulse"}, 32'(Dcache_req), 32'd0);
      midCycle();
      if (Dstall) stall_cnt++;
    end
    nextCycle();
    Dcache_valid = 1'b1;
    Dcache_rdata = rdata;
    midCycle();
    if (Dstall) stall_cnt++;
    checkOutput({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(1 + lat));
    nextCycle();
    Dcache_valid = 1'b0;
    Dcache_rdata = 32'h0;
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 3'b000, 32'h0, 5'd0);
    checkOutput({tag, "_wb_data"}, WB_data, exp_wb);
    checkOutput({tag, "_reg_write"}, 32'(reg_write_WB), 32'(exp_rw));
  endtask

  initial begin
    rst          = 1'b0;
    Istall       = 1'b0;
    wfi_stall    = 1'b0;
    Dcache_valid = 1'b0;
    Dcache_rdata = 32'h0;
    PC_added_MEM = 32'h0;
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 3'b000, 32'h0, 5'd0);
    #12;
    checkOutput("rst_req", 32'(Dcache_req), 32'd0);
    checkOutput("rst_wb_data", WB_data, 32'h0);
    checkOutput("rst_reg_write", 32'(reg_write_WB), 32'd0);
    checkOutput("rst_waddr", 32'(write_addr_WB), 32'd0);
    checkOutput("rst_dstall", 32'(Dstall), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    nextCycle();

    // ALU pass-through with no memory op.
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 3'b001, 32'h7, 5'd5);
    midCycle();
    checkOutput("add_dstall", 32'(Dstall), 32'd0);
    nextCycle();
    checkOutput("add_wb_data", WB_data, 32'h7);
    checkOutput("add_reg_write", 32'(reg_write_WB), 32'd1);
    checkOutput("add_waddr", 32'(write_addr_WB), 32'd5);

    // Loads.
    runAccess("lw", 1'b0, 3'b010, 32'h100, 32'h0, 3'b011, 32'h0,
              32'hDEADBEEF, 3, 4'h0, 32'h0, 32'hDEADBEEF, 1'b1);
    runAccess("lb", 1'b0, 3'b000, 32'h103, 32'h0, 3'b011, 32'h0,
              32'h80AABBCC, 1, 4'h0, 32'h0, 32'hFFFFFF80, 1'b1);
    runAccess("lbu", 1'b0, 3'b100, 32'h103, 32'h0, 3'b011, 32'h0,
              32'h80AABBCC, 1, 4'h0, 32'h0, 32'h00000080, 1'b1);
    runAccess("lh", 1'b0, 3'b001, 32'h102, 32'h0, 3'b011, 32'h0,
              32'h80AABBCC, 2, 4'h0, 32'h0, 32'hFFFF80AA, 1'b1);
    runAccess("lhu", 1'b0, 3'b101, 32'h100, 32'h0, 3'b011, 32'h0,
              32'h80AABBCC, 1, 4'h0, 32'h0, 32'h0000BBCC, 1'b1);

    // Stores: WB carries the ALU value, no register write.
    runAccess("sb", 1'b1, 3'b000, 32'h201, 32'h0000005A, 3'b000, 32'h201,
              32'h0, 1, 4'b0010, 32'h5A5A5A5A, 32'h201, 1'b0);
    runAccess("sh", 1'b1, 3'b001, 32'h302, 32'h1234BEEF, 3'b000, 32'h302,
              32'h0, 2, 4'b1100, 32'hBEEFBEEF, 32'h302, 1'b0);
`ifndef MEM_MISALIGN_CHECK_EN
    runAccess("sw_unaligned", 1'b1, 3'b010, 32'h203, 32'hCAFEF00D, 3'b000,
              32'h203, 32'h0, 1, 4'b1111, 32'hCAFEF00D, 32'h203, 1'b0);
`endif

    // Load response under Istall goes through HOLD.
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 3'b001, 32'h11111111, 5'd3);
    nextCycle();
    checkOutput("pre_hold_wb", WB_data, 32'h11111111);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 3'b011, 32'h0, 5'd4);
    nextCycle();
    nextCycle();
    Dcache_valid = 1'b1;
    Dcache_rdata = 32'h12345678;
    Istall       = 1'b1;
    midCycle();
    checkOutput("hold_valid_dstall", 32'(Dstall), 32'd0);
    nextCycle();
    Dcache_valid = 1'b0;
    Dcache_rdata = 32'h0;
    checkOutput("hold_wb_old1", WB_data, 32'h11111111);
    midCycle();
    checkOutput("hold_dstall", 32'(Dstall), 32'd0);
    nextCycle();
    checkOutput("hold_wb_old2", WB_data, 32'h11111111);
    Istall = 1'b0;
    nextCycle();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 3'b000, 32'h0, 5'd0);
    checkOutput("hold_wb_new", WB_data, 32'h12345678);
    checkOutput("hold_waddr", 32'(write_addr_WB), 32'd4);

    // Reset asserted while waiting for the cache.
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 3'b011, 32'h0, 5'd6);
    nextCycle();
    checkOutput("wait_req_before_rst", 32'(Dcache_req), 32'd1);
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 3'b000, 32'h0, 5'd0);
    rst = 1'b0;
    #1;
    checkOutput("wait_rst_req", 32'(Dcache_req), 32'd0);
    checkOutput("wait_rst_addr", Dcache_addr, 32'h0);
    checkOutput("wait_rst_wb_data", WB_data, 32'h0);
    checkOutput("wait_rst_dstall", 32'(Dstall), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    nextCycle();

    // Stray valid in IDLE is ignored; pc_to_reg has priority.
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 3'b111, 32'h99, 5'd7);
    PC_added_MEM = 32'h44;
    Dcache_valid = 1'b1;
    Dcache_rdata = 32'hFFFFFFFF;
    midCycle();
    checkOutput("stray_valid_dstall", 32'(Dstall), 32'd0);
    nextCycle();
    Dcache_valid = 1'b0;
    checkOutput("stray_valid_req", 32'(Dcache_req), 32'd0);
    checkOutput("pc_to_reg_wb", WB_data, 32'h44);
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 3'b001, 32'h99, 5'd7);
    nextCycle();
    checkOutput("post_rst_alu_wb", WB_data, 32'h99);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
